// File: rtl/winner_resp_engine.sv
// Winner-side req/ack responder: captures one request, waits LATENCY cycles,
// returns a mode-dependent result and counts completed handshakes.
module winner_resp_engine #(
  parameter int unsigned REQ_DATA_WIDTH = 8,
  parameter int unsigned ACK_DATA_WIDTH = 8,
  parameter int unsigned LATENCY        = 2,
  parameter int unsigned OFFSET         = 16,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      winner_req,
  input  logic [1:0]                winner_mode,
  input  logic [REQ_DATA_WIDTH-1:0] winner_data_req,
  output logic                      winner_ack,
  output logic [ACK_DATA_WIDTH-1:0] winner_data_ack,
  output logic                      busy,
  output logic                      abort_err,
  output logic [CNT_WIDTH-1:0]      txn_cnt
);

  localparam int unsigned WAIT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [WAIT_W-1:0]         wait_q, wait_d;
  logic [1:0]                mode_q, mode_d;
  logic [ACK_DATA_WIDTH-1:0] data_q, data_d;
  logic                      ack_q, ack_d;
  logic [ACK_DATA_WIDTH-1:0] dack_q, dack_d;
  logic                      busy_q, busy_d;
  logic                      abort_q, abort_d;
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
  logic [ACK_DATA_WIDTH-1:0] result_c;

  // Response value from the captured mode and payload; sums wrap naturally.
  always_comb begin
    result_c = data_q;
    case (mode_q)
      2'b00:   result_c = data_q;
      2'b01:   result_c = data_q + ACK_DATA_WIDTH'(1);
      2'b10:   result_c = data_q + ACK_DATA_WIDTH'(OFFSET);
      default: result_c = ~data_q;
    endcase
  end

  // Next-state and next-output logic for the four-phase handshake.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    mode_d  = mode_q;
    data_d  = data_q;
    ack_d   = ack_q;
    dack_d  = dack_q;
    cnt_d   = cnt_q;
    abort_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (winner_req) begin
          mode_d  = winner_mode;
          data_d  = ACK_DATA_WIDTH'(winner_data_req);
          wait_d  = WAIT_W'(LATENCY);
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (!winner_req) begin
          abort_d = 1'b1;
          state_d = S_IDLE;
        end else if (wait_q != '0) begin
          wait_d = wait_q - WAIT_W'(1);
        end else begin
          ack_d   = 1'b1;
          dack_d  = result_c;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (!winner_req) begin
          ack_d   = 1'b0;
          dack_d  = '0;
          cnt_d   = cnt_q + CNT_WIDTH'(1);
          state_d = S_IDLE;
        end
      end
      default: begin
        ack_d   = 1'b0;
        dack_d  = '0;
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      mode_q  <= '0;
      data_q  <= '0;
      ack_q   <= 1'b0;
      dack_q  <= '0;
      busy_q  <= 1'b0;
      abort_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      dack_q  <= dack_d;
      busy_q  <= busy_d;
      abort_q <= abort_d;
      cnt_q   <= cnt_d;
    end
  end

  assign winner_ack      = ack_q;
  assign winner_data_ack = dack_q;
  assign busy            = busy_q;
  assign abort_err       = abort_q;
  assign txn_cnt         = cnt_q;

endmodule

// File: tb/tb_winner_resp_engine.sv
// Randomized self-checking bench: three responders with LATENCY 2, 3 and 0,
// each checked cycle by cycle against a transaction-level model.
module tb_winner_resp_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req   [3];
  logic [1:0] mode  [3];
  logic [7:0] dreq  [3];
  logic       ack   [3];
  logic [7:0] dack  [3];
  logic       busy  [3];
  logic       abort [3];
  logic [3:0] cnt   [3];

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt [3];

  always #5 clk = ~clk;

  winner_resp_engine #(.LATENCY(2), .CNT_WIDTH(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .winner_req(req[0]), .winner_mode(mode[0]),
    .winner_data_req(dreq[0]), .winner_ack(ack[0]), .winner_data_ack(dack[0]),
    .busy(busy[0]), .abort_err(abort[0]), .txn_cnt(cnt[0]));

  winner_resp_engine #(.LATENCY(3), .CNT_WIDTH(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .winner_req(req[1]), .winner_mode(mode[1]),
    .winner_data_req(dreq[1]), .winner_ack(ack[1]), .winner_data_ack(dack[1]),
    .busy(busy[1]), .abort_err(abort[1]), .txn_cnt(cnt[1]));

  winner_resp_engine #(.LATENCY(0), .CNT_WIDTH(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .winner_req(req[2]), .winner_mode(mode[2]),
    .winner_data_req(dreq[2]), .winner_ack(ack[2]), .winner_data_ack(dack[2]),
    .busy(busy[2]), .abort_err(abort[2]), .txn_cnt(cnt[2]));

  // Compare one observed value against its expectation.
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : (i == 1) ? 3 : 0;
  endfunction

  // Expected response from the operation table, in plain integer arithmetic.
  function automatic int model_result(input int m, input int d);
    case (m)
      0:       return d;
      1:       return (d + 1) % 256;
      2:       return (d + 16) % 256;
      default: return 255 - d;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input int i, input string tag);
    check({tag, "_ack"},   int'(ack[i]),   0);
    check({tag, "_dack"},  int'(dack[i]),  0);
    check({tag, "_busy"},  int'(busy[i]),  0);
    check({tag, "_abort"}, int'(abort[i]), 0);
    check({tag, "_cnt"},   int'(cnt[i]),   exp_cnt[i]);
  endtask

  // Full handshake; optionally scrambles inputs after capture.
  task automatic txn(input int i, input int m, input int d, input int hold, input bit scramble);
    int exp;
    exp = model_result(m, d);
    req[i] = 1'b1; mode[i] = 2'(m); dreq[i] = 8'(d);
    step();
    check("cap_busy", int'(busy[i]), 1);
    check("cap_ack",  int'(ack[i]),  0);
    for (int j = 0; j < lat_of(i); j++) begin
      if (scramble) begin mode[i] = 2'($urandom); dreq[i] = 8'($urandom); end
      step();
      check("wait_ack", int'(ack[i]), 0);
    end
    if (scramble) begin mode[i] = 2'($urandom); dreq[i] = 8'($urandom); end
    step();
    check("ack_rise",  int'(ack[i]),   1);
    check("ack_data",  int'(dack[i]),  exp);
    check("ack_busy",  int'(busy[i]),  1);
    check("ack_abort", int'(abort[i]), 0);
    for (int j = 0; j < hold; j++) begin
      if (scramble) begin mode[i] = 2'($urandom); dreq[i] = 8'($urandom); end
      step();
      check("hold_ack",  int'(ack[i]),  1);
      check("hold_data", int'(dack[i]), exp);
    end
    req[i] = 1'b0;
    step();
    exp_cnt[i] = (exp_cnt[i] + 1) % 16;
    check_idle(i, "drop");
  endtask

  // Request withdrawn after n cycles in BUSY (n never exceeds the latency).
  task automatic abort_txn(input int i, input int n);
    req[i] = 1'b1; mode[i] = 2'($urandom); dreq[i] = 8'($urandom);
    step();
    check("ab_busy", int'(busy[i]), 1);
    for (int j = 0; j < n; j++) begin
      step();
      check("ab_wait_ack", int'(ack[i]), 0);
    end
    req[i] = 1'b0;
    step();
    check("ab_pulse", int'(abort[i]), 1);
    check("ab_ack",   int'(ack[i]),   0);
    check("ab_cnt",   int'(cnt[i]),   exp_cnt[i]);
    step();
    check_idle(i, "ab_after");
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b0; mode[i] = 2'd0; dreq[i] = 8'd0; exp_cnt[i] = 0;
    end
    step();
    for (int i = 0; i < 3; i++) check_idle(i, "rst");
    rst_n = 1'b1;
    step();

    // Basic handshake: 0x41 + 1, LATENCY 2
    txn(0, 1, 'h41, 1, 1'b0);
    check("t2_cnt", int'(cnt[0]), 1);

    // Asynchronous reset while BUSY
    req[0] = 1'b1; mode[0] = 2'd3; dreq[0] = 8'h12;
    step();
    check("t1_busy", int'(busy[0]), 1);
    #2 rst_n = 1'b0;
    req[0] = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) exp_cnt[i] = 0;
    check_idle(0, "t1_async");
    step();
    rst_n = 1'b1;
    step();
    check_idle(0, "t1_release");

    // Wrap and inversion corners
    txn(0, 1, 'hFF, 0, 1'b0);
    txn(0, 2, 'hF8, 0, 1'b0);
    txn(0, 3, 'h0F, 2, 1'b0);
    txn(0, 0, 'h5A, 0, 1'b0);

    // Aborts on each latency
    abort_txn(1, 1);
    abort_txn(0, 2);
    abort_txn(2, 0);

    // Inputs scrambled after capture
    txn(1, 2, 'h33, 3, 1'b1);
    txn(0, 3, 'hA5, 2, 1'b1);

    // Back-to-back with LATENCY 0: 17 transactions wrap a 4-bit counter to 1
    for (int k = 0; k < 17; k++)
      txn(2, int'($urandom_range(3, 0)), int'($urandom_range(255, 0)), 0, 1'b0);
    check("t6_wrap", int'(cnt[2]), 1);

    // Randomized mix of transactions, aborts and gaps
    for (int k = 0; k < 60; k++) begin
      int i;
      i = int'($urandom_range(2, 0));
      if ($urandom_range(3, 0) == 0)
        abort_txn(i, int'($urandom_range(lat_of(i), 0)));
      else
        txn(i, int'($urandom_range(3, 0)), int'($urandom_range(255, 0)),
            int'($urandom_range(3, 0)), 1'($urandom));
      for (int g = 0; g < int'($urandom_range(2, 0)); g++) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
